// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the req/ack instruction bus,
// and presents if_pc/if_inst to the IF/ID register.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic        ibus_req_o,
   output logic [31:0] ibus_addr_o,
   input  logic        ibus_ack_i,
   input  logic [31:0] ibus_rdata_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        stallreq_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_HOLD
   } state_t;

   localparam logic [31:0] STEP = 32'(PC_STEP);

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic        pend_valid, pend_valid_next;
   logic [31:0] pend_target, pend_target_next;
   logic [31:0] buffer, buffer_next;
   logic [31:0] hold_pc, hold_pc_next;
   logic        advance;

   logic [31:0] branch_pc;
   logic [31:0] flush_pc;
   logic [31:0] seq_pc;

   // Only stall[0] gates fetch; IF/ID handles stall[1] itself.
   logic        unused_stall;
   assign unused_stall = ^stall[5:1];

   assign branch_pc = {branch_target_i[31:2], 2'b00};
   assign flush_pc  = {new_pc_i[31:2], 2'b00};
   assign seq_pc    = pc + STEP;

   // Next-state, PC selection and bus/pipeline outputs.
   always_comb begin
      state_next       = state;
      pc_next          = pc;
      pend_valid_next  = pend_valid;
      pend_target_next = pend_target;
      buffer_next      = buffer;
      hold_pc_next     = hold_pc;
      advance          = 1'b0;
      ibus_req_o       = 1'b0;
      ibus_addr_o      = '0;
      if_pc_o          = '0;
      if_inst_o        = '0;
      stallreq_o       = 1'b0;

      if (rst) begin
         // Registers are reset in the sequential block; outputs stay 0.
      end else if (flush_i) begin
         // Flush overrides any ack or branch seen in this cycle.
         state_next      = S_REQ;
         pc_next         = flush_pc;
         pend_valid_next = 1'b0;
         buffer_next     = '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               state_next = S_REQ;
            end
            S_REQ: begin
               ibus_req_o  = 1'b1;
               ibus_addr_o = pc;
               if (ibus_ack_i) begin
                  if_pc_o   = pc;
                  if_inst_o = ibus_rdata_i;
                  if (!stall[0]) begin
                     advance = 1'b1;
                  end else begin
                     buffer_next  = ibus_rdata_i;
                     hold_pc_next = pc;
                     state_next   = S_HOLD;
                  end
               end else begin
                  stallreq_o = 1'b1;
               end
            end
            S_HOLD: begin
               if_pc_o   = hold_pc;
               if_inst_o = buffer;
               if (!stall[0]) begin
                  advance    = 1'b1;
                  state_next = S_REQ;
               end
            end
            default: begin
               state_next = S_IDLE;
            end
         endcase

         // A branch that cannot redirect now is remembered for the next advance.
         if (advance) begin
            if (branch_flag_i) begin
               pc_next = branch_pc;
            end else if (pend_valid) begin
               pc_next = pend_target;
            end else begin
               pc_next = seq_pc;
            end
            pend_valid_next = 1'b0;
         end else if (branch_flag_i) begin
            pend_valid_next  = 1'b1;
            pend_target_next = branch_pc;
         end
      end
   end

   // State and PC registers with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         pend_valid  <= 1'b0;
         pend_target <= '0;
         buffer      <= '0;
         hold_pc     <= '0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         pend_valid  <= pend_valid_next;
         pend_target <= pend_target_next;
         buffer      <= buffer_next;
         hold_pc     <= hold_pc_next;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        ibus_req_o;
   logic [31:0] ibus_addr_o;
   logic        ibus_ack_i;
   logic [31:0] ibus_rdata_i;
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        stallreq_o;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Behavioural model: "started" = reset idle cycle is over,
   // "holding" = a delivered word is parked while the PC is held.
   logic        m_started;
   logic        m_holding;
   logic [31:0] m_pc;
   logic        m_pend;
   logic [31:0] m_pend_tgt;
   logic [31:0] m_word;
   logic [31:0] m_word_pc;

   if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .flush_i         (flush_i),
      .new_pc_i        (new_pc_i),
      .ibus_req_o      (ibus_req_o),
      .ibus_addr_o     (ibus_addr_o),
      .ibus_ack_i      (ibus_ack_i),
      .ibus_rdata_i    (ibus_rdata_i),
      .if_pc_o         (if_pc_o),
      .if_inst_o       (if_inst_o),
      .stallreq_o      (stallreq_o)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Compare DUT outputs with the model, then advance the model one clock.
   task automatic model_cycle();
      logic        e_req, e_sreq, adv;
      logic [31:0] e_addr, e_pc, e_inst, tgt;
      e_req = 0; e_sreq = 0; e_addr = 0; e_pc = 0; e_inst = 0; adv = 0;
      tgt = {branch_target_i[31:2], 2'b00};
      if (!rst && !flush_i && m_started) begin
         if (m_holding) begin
            e_pc   = m_word_pc;
            e_inst = m_word;
         end else begin
            e_req  = 1;
            e_addr = m_pc;
            if (ibus_ack_i) begin
               e_pc   = m_pc;
               e_inst = ibus_rdata_i;
            end else begin
               e_sreq = 1;
            end
         end
      end
      check("req",      {31'b0, ibus_req_o}, {31'b0, e_req});
      check("addr",     ibus_addr_o, e_addr);
      check("if_pc",    if_pc_o, e_pc);
      check("if_inst",  if_inst_o, e_inst);
      check("stallreq", {31'b0, stallreq_o}, {31'b0, e_sreq});

      if (rst) begin
         m_started = 0; m_holding = 0; m_pc = 0; m_pend = 0; m_word = 0;
      end else if (flush_i) begin
         m_started = 1; m_holding = 0; m_pend = 0; m_word = 0;
         m_pc = {new_pc_i[31:2], 2'b00};
      end else if (!m_started) begin
         m_started = 1;
         if (branch_flag_i) begin m_pend = 1; m_pend_tgt = tgt; end
      end else begin
         if (m_holding) adv = !stall[0];
         else if (ibus_ack_i) begin
            if (!stall[0]) adv = 1;
            else begin
               m_holding = 1; m_word = ibus_rdata_i; m_word_pc = m_pc;
            end
         end
         if (adv) begin
            m_holding = 0;
            m_pc = branch_flag_i ? tgt : (m_pend ? m_pend_tgt : m_pc + 32'd4);
            m_pend = 0;
         end else if (branch_flag_i) begin
            m_pend = 1; m_pend_tgt = tgt;
         end
      end
   endtask

   task automatic cyc(input logic r, input logic s0, input logic a, input logic [31:0] d,
                      input logic b, input logic [31:0] bt, input logic f, input logic [31:0] np);
      @(negedge clk);
      rst = r; stall = {5'b0, s0}; ibus_ack_i = a; ibus_rdata_i = d;
      branch_flag_i = b; branch_target_i = bt; flush_i = f; new_pc_i = np;
      #1;
      model_cycle();
   endtask

   initial begin
      rst = 1; stall = 0; branch_flag_i = 0; branch_target_i = 0;
      flush_i = 0; new_pc_i = 0; ibus_ack_i = 0; ibus_rdata_i = 0;
      m_started = 0; m_holding = 0; m_pc = 0; m_pend = 0; m_pend_tgt = 0;
      m_word = 0; m_word_pc = 0;

      // Reset and idle cycle
      cyc(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
      check("rst_inst", if_inst_o, 32'h0);
      cyc(1, 0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hA000_0000, 0, 0, 0, 0);
      check("idle_req", {31'b0, ibus_req_o}, 32'h0);
      // Zero-wait fetch at 0x0, then wait states at 0x4
      cyc(0, 0, 1, 32'hA000_0000, 0, 0, 0, 0);
      check("zw_addr0", ibus_addr_o, 32'h0);
      cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
      check("ws_addr", ibus_addr_o, 32'h4);
      check("ws_sreq", {31'b0, stallreq_o}, 32'h1);
      cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hA000_0004, 0, 0, 0, 0);
      check("ws_inst", if_inst_o, 32'hA000_0004);
      // PC stall on ack at 0x8
      cyc(0, 1, 1, 32'h2402_0005, 0, 0, 0, 0);
      check("st_addr", ibus_addr_o, 32'h8);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 1, 1, 32'h1111_1111, 0, 0, 0, 0);
         check("st_hold", if_inst_o, 32'h2402_0005);
      end
      cyc(0, 0, 1, 32'h1111_1111, 0, 0, 0, 0);
      // Branch resolved with ack at 0xC, target low bits masked
      cyc(0, 0, 1, 32'hA000_000C, 1, 32'h103, 0, 0);
      check("br_slot", ibus_addr_o, 32'hC);
      cyc(0, 0, 0, 32'h0, 1, 32'h200, 0, 0);
      check("br_addr", ibus_addr_o, 32'h100);
      // Pending branch completes 0x100 first
      cyc(0, 0, 1, 32'hA000_0100, 0, 0, 0, 0);
      check("pend_slot", if_pc_o, 32'h100);
      cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
      check("pend_addr", ibus_addr_o, 32'h200);
      // Flush with simultaneous branch
      cyc(0, 0, 1, 32'hA000_0200, 1, 32'h300, 1, 32'h182);
      check("fl_req", {31'b0, ibus_req_o}, 32'h0);
      check("fl_inst", if_inst_o, 32'h0);
      cyc(0, 0, 1, 32'hA000_0180, 0, 0, 0, 0);
      check("fl_addr", ibus_addr_o, 32'h180);
      cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
      check("fl_nobr", ibus_addr_o, 32'h184);
      // Reset mid-request
      cyc(1, 0, 1, 32'hA000_0184, 0, 0, 0, 0);
      check("mr_req", {31'b0, ibus_req_o}, 32'h0);
      cyc(0, 0, 1, 32'h0, 0, 0, 0, 0);
      cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
      check("mr_addr", ibus_addr_o, 32'h0);
      // Wrap from 0xFFFF_FFFC
      cyc(0, 0, 0, 32'h0, 0, 0, 1, 32'hFFFF_FFFF);
      cyc(0, 0, 1, 32'hA000_FFFC, 0, 0, 0, 0);
      check("wr_top", ibus_addr_o, 32'hFFFF_FFFC);
      cyc(0, 0, 0, 32'h0, 0, 0, 0, 0);
      check("wr_zero", ibus_addr_o, 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] bt, np;
         bt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom;
         np = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFD : $urandom;
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 0), $urandom,
             ($urandom_range(0, 7) == 0), bt,
             ($urandom_range(0, 29) == 0), np);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
